m_stopwatch_ctrl: RTL and testbench

Downstream consumer of the modulo sub-second counter. Takes that counter's one-cycle wrap pulse and current count, and accumulates seconds and minutes. A start/stop/lap/clear state machine is driven by two push-buttons. It outputs live or lap-frozen display values plus control lines back to the counter's enable and clear.

---
 rtl/m_stopwatch_ctrl_pkg.sv | 16 +
 rtl/m_stopwatch_ctrl_if.sv | 27 ++
 rtl/m_stopwatch_ctrl_btn_edge.sv | 28 ++
 rtl/m_stopwatch_ctrl.sv | 132 +++++++++++++
 tb/tb_m_stopwatch_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/m_stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller slice.
// Holds the field width, the default moduli and the FSM state encoding.
package m_stopwatch_ctrl_pkg;

   localparam int W       = 6;
   localparam int SEC_MOD = 60;
   localparam int MIN_MOD = 60;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STOP = 2'd2,
      S_LAP  = 2'd3
   } state_t;

endpackage

// File: rtl/m_stopwatch_ctrl_if.sv
// Signal bundle between the upstream counter/buttons (master) and the stopwatch controller (slave).
interface m_stopwatch_ctrl_if;
   import m_stopwatch_ctrl_pkg::*;

   logic         tick;
   logic [W-1:0] sub;
   logic         btn_ss;
   logic         btn_lap;
   logic         cnt_run;
   logic         cnt_clr;
   logic [W-1:0] disp_sub;
   logic [W-1:0] disp_sec;
   logic [W-1:0] disp_min;
   logic         lap_held;
   logic         ovf;

   modport master (
      output tick, sub, btn_ss, btn_lap,
      input  cnt_run, cnt_clr, disp_sub, disp_sec, disp_min, lap_held, ovf
   );

   modport slave (
      input  tick, sub, btn_ss, btn_lap,
      output cnt_run, cnt_clr, disp_sub, disp_sec, disp_min, lap_held, ovf
   );

endinterface

// File: rtl/m_stopwatch_ctrl_btn_edge.sv
// Two-flop synchroniser plus rising-edge detector for one debounced button.
// A button held through reset release produces exactly one pulse.
module m_btn_edge (
   input  logic ck,
   input  logic res,
   input  logic btn,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge ck) begin
      if (res) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise = sync2 & ~prev;

endmodule

// File: rtl/m_stopwatch_ctrl.sv
// Stopwatch controller: seconds/minutes accumulation, start/stop/lap/clear FSM
// and display multiplexing between live and lap-frozen values.
module m_stopwatch_ctrl #(
   parameter int SEC_MOD = m_stopwatch_ctrl_pkg::SEC_MOD,
   parameter int MIN_MOD = m_stopwatch_ctrl_pkg::MIN_MOD
) (
   input logic               ck,
   input logic               res,
   m_stopwatch_ctrl_if.slave bus
);
   import m_stopwatch_ctrl_pkg::*;

   localparam logic [W-1:0] SEC_LAST = W'(SEC_MOD - 1);
   localparam logic [W-1:0] MIN_LAST = W'(MIN_MOD - 1);

   state_t       state;
   state_t       state_nxt;
   logic         ss_edge;
   logic         lap_edge;
   logic         do_latch;
   logic         do_clear;
   logic         tick_ok;
   logic [W-1:0] sec;
   logic [W-1:0] min;
   logic [W-1:0] lap_sub;
   logic [W-1:0] lap_sec;
   logic [W-1:0] lap_min;
   logic         ovf_q;
   logic         run_q;
   logic         clr_q;
   logic         held_q;

   m_btn_edge u_ss_edge (
      .ck   (ck),
      .res  (res),
      .btn  (bus.btn_ss),
      .rise (ss_edge)
   );

   m_btn_edge u_lap_edge (
      .ck   (ck),
      .res  (res),
      .btn  (bus.btn_lap),
      .rise (lap_edge)
   );

   // Start/stop edge always takes precedence; a simultaneous lap edge is dropped.
   always_comb begin
      state_nxt = state;
      do_latch  = 1'b0;
      do_clear  = 1'b0;
      case (state)
         S_IDLE: if (ss_edge) state_nxt = S_RUN;
         S_RUN: begin
            if (ss_edge) begin
               state_nxt = S_STOP;
            end else if (lap_edge) begin
               state_nxt = S_LAP;
               do_latch  = 1'b1;
            end
         end
         S_LAP: begin
            if (ss_edge)       state_nxt = S_STOP;
            else if (lap_edge) state_nxt = S_RUN;
         end
         S_STOP: begin
            if (ss_edge) begin
               state_nxt = S_RUN;
            end else if (lap_edge) begin
               state_nxt = S_IDLE;
               do_clear  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign tick_ok = bus.tick && (state == S_RUN || state == S_LAP);

   always_ff @(posedge ck) begin
      if (res) begin
         state   <= S_IDLE;
         sec     <= '0;
         min     <= '0;
         ovf_q   <= 1'b0;
         lap_sub <= '0;
         lap_sec <= '0;
         lap_min <= '0;
         run_q   <= 1'b0;
         clr_q   <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         run_q  <= (state_nxt == S_RUN) || (state_nxt == S_LAP);
         held_q <= (state_nxt == S_LAP);
         clr_q  <= do_clear;
         if (tick_ok) begin
            if (sec == SEC_LAST) begin
               sec <= '0;
               if (min == MIN_LAST) begin
                  min   <= '0;
                  ovf_q <= 1'b1;
               end else begin
                  min <= min + 1'b1;
               end
            end else begin
               sec <= sec + 1'b1;
            end
         end
         // The latch sees pre-increment values even when a tick lands on the same edge.
         if (do_latch) begin
            lap_sub <= bus.sub;
            lap_sec <= sec;
            lap_min <= min;
         end
         if (do_clear) begin
            sec   <= '0;
            min   <= '0;
            ovf_q <= 1'b0;
         end
      end
   end

   assign bus.disp_sub = (state == S_LAP) ? lap_sub : bus.sub;
   assign bus.disp_sec = (state == S_LAP) ? lap_sec : sec;
   assign bus.disp_min = (state == S_LAP) ? lap_min : min;
   assign bus.cnt_run  = run_q;
   assign bus.cnt_clr  = clr_q;
   assign bus.lap_held = held_q;
   assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_m_stopwatch_ctrl.sv
// Directed testbench for m_stopwatch_ctrl with hand-computed expected values.
module tb_m_stopwatch_ctrl;
   import m_stopwatch_ctrl_pkg::*;

   logic ck = 1'b0;
   logic res;
   int   checks = 0;
   int   errors = 0;
   int   clr_count = 0;

   m_stopwatch_ctrl_if bus ();

   m_stopwatch_ctrl dut (
      .ck  (ck),
      .res (res),
      .bus (bus)
   );

   always #5 ck = ~ck;

   always @(negedge ck) begin
      if (bus.cnt_clr === 1'b1) clr_count++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Press buttons; rise pulses in the third cycle, optional tick sampled at the update edge.
   task automatic applyStimulus(input logic ss, input logic lap, input logic tk);
      bus.btn_ss  = ss;
      bus.btn_lap = lap;
      step();
      step();
      bus.tick = tk;
      step();
      bus.tick = 1'b0;
   endtask

   task automatic releaseButtons();
      bus.btn_ss  = 1'b0;
      bus.btn_lap = 1'b0;
      repeat (3) step();
   endtask

   task automatic sendTicks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = 1'b1;
         step();
         bus.tick = 1'b0;
         step();
      end
   endtask

   initial begin
      res         = 1'b1;
      bus.tick    = 1'b0;
      bus.sub     = 6'd17;
      bus.btn_ss  = 1'b0;
      bus.btn_lap = 1'b0;
      repeat (3) step();
      res = 1'b0;
      step();
      checkOutput("rst_cnt_run", bus.cnt_run, 0);
      checkOutput("rst_cnt_clr", bus.cnt_clr, 0);
      checkOutput("rst_lap_held", bus.lap_held, 0);
      checkOutput("rst_ovf", bus.ovf, 0);
      checkOutput("rst_sec", bus.disp_sec, 0);
      checkOutput("rst_min", bus.disp_min, 0);
      checkOutput("rst_sub_pass", bus.disp_sub, 17);

      for (int i = 0; i < 10; i++) begin
         sendTicks(1);
         checkOutput("idle_cnt_run", bus.cnt_run, 0);
      end
      checkOutput("idle_sec", bus.disp_sec, 0);
      checkOutput("idle_min", bus.disp_min, 0);

      bus.btn_ss = 1'b1;
      step();
      step();
      checkOutput("start_not_yet", bus.cnt_run, 0);
      step();
      checkOutput("start_cnt_run", bus.cnt_run, 1);
      releaseButtons();

      bus.tick = 1'b1;
      checkOutput("tick_before_edge", bus.disp_sec, 0);
      step();
      bus.tick = 1'b0;
      checkOutput("tick_latency", bus.disp_sec, 1);
      step();
      sendTicks(60);
      checkOutput("run61_sec", bus.disp_sec, 1);
      checkOutput("run61_min", bus.disp_min, 1);

      sendTicks(4);
      checkOutput("pre_lap_sec", bus.disp_sec, 5);
      bus.sub = 6'd42;
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("lap_held", bus.lap_held, 1);
      checkOutput("lap_disp_sec", bus.disp_sec, 5);
      checkOutput("lap_disp_min", bus.disp_min, 1);
      checkOutput("lap_disp_sub", bus.disp_sub, 42);
      checkOutput("lap_cnt_run", bus.cnt_run, 1);
      bus.sub = 6'd9;
      step();
      checkOutput("lap_sub_frozen", bus.disp_sub, 42);
      releaseButtons();
      sendTicks(1);
      checkOutput("lap_sec_frozen", bus.disp_sec, 5);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("unlap_held", bus.lap_held, 0);
      checkOutput("unlap_sec", bus.disp_sec, 7);
      checkOutput("unlap_min", bus.disp_min, 1);
      checkOutput("unlap_sub", bus.disp_sub, 9);
      releaseButtons();

      sendTicks(3532);
      checkOutput("max_sec", bus.disp_sec, 59);
      checkOutput("max_min", bus.disp_min, 59);
      checkOutput("max_ovf", bus.ovf, 0);
      sendTicks(1);
      checkOutput("wrap_sec", bus.disp_sec, 0);
      checkOutput("wrap_min", bus.disp_min, 0);
      checkOutput("wrap_ovf", bus.ovf, 1);
      sendTicks(3);
      checkOutput("post_wrap_sec", bus.disp_sec, 3);
      checkOutput("ovf_sticky", bus.ovf, 1);

      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("stop_cnt_run", bus.cnt_run, 0);
      releaseButtons();
      sendTicks(2);
      checkOutput("stop_ticks_ignored", bus.disp_sec, 3);
      checkOutput("stop_clr_quiet", clr_count, 0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("clear_pulse", bus.cnt_clr, 1);
      checkOutput("clear_sec", bus.disp_sec, 0);
      checkOutput("clear_min", bus.disp_min, 0);
      checkOutput("clear_ovf", bus.ovf, 0);
      step();
      checkOutput("clear_pulse_end", bus.cnt_clr, 0);
      releaseButtons();
      checkOutput("clear_pulse_count", clr_count, 1);

      applyStimulus(1'b1, 1'b0, 1'b0);
      releaseButtons();
      sendTicks(2);
      bus.sub = 6'd30;
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("both_cnt_run", bus.cnt_run, 0);
      checkOutput("both_lap_held", bus.lap_held, 0);
      checkOutput("both_sec_live", bus.disp_sec, 2);
      checkOutput("both_sub_live", bus.disp_sub, 30);
      releaseButtons();

      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("restart_cnt_run", bus.cnt_run, 1);
      checkOutput("restart_tick_dropped", bus.disp_sec, 2);
      releaseButtons();
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("stop_tick_counted", bus.disp_sec, 3);
      checkOutput("stop2_cnt_run", bus.cnt_run, 0);
      releaseButtons();

      applyStimulus(1'b1, 1'b0, 1'b0);
      releaseButtons();
      sendTicks(4);
      bus.sub = 6'd50;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("lap7_held", bus.lap_held, 1);
      checkOutput("lap7_sec", bus.disp_sec, 7);
      releaseButtons();
      res = 1'b1;
      step();
      res = 1'b0;
      checkOutput("midrst_lap_held", bus.lap_held, 0);
      checkOutput("midrst_cnt_run", bus.cnt_run, 0);
      checkOutput("midrst_cnt_clr", bus.cnt_clr, 0);
      checkOutput("midrst_sec", bus.disp_sec, 0);
      checkOutput("midrst_min", bus.disp_min, 0);
      checkOutput("midrst_sub", bus.disp_sub, 50);
      checkOutput("midrst_clr_count", clr_count, 1);

      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("after_rst_start", bus.cnt_run, 1);
      releaseButtons();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
